// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the sp_ram_ex single-port RAM.
// Optional power-up clear is enabled with SP_RAM_EX_CLEAR_EN.
package sp_ram_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        RDW_WRITE_FIRST = 2'd0,
        RDW_READ_FIRST  = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/sp_ram_clr.sv
// Zero-fill sequencer: walks every address once after reset release, then opens ready.
// Instantiated by sp_ram_ex only when SP_RAM_EX_CLEAR_EN is defined.
module sp_ram_clr
    import sp_ram_pkg::*;
#(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    clr_state_e    r_state;
    clr_state_e    w_nxt_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_nxt_addr;
    logic          r_ready;
    logic          r_clr_we;

    // State, address and registered outputs; reset always restarts the fill at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CLEAR;
            r_addr   <= '0;
            r_ready  <= 1'b0;
            r_clr_we <= 1'b1;
        end else begin
            r_state  <= w_nxt_state;
            r_addr   <= w_nxt_addr;
            r_ready  <= (w_nxt_state == IDLE);
            r_clr_we <= (w_nxt_state == CLEAR);
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_addr  = r_addr;
        case (r_state)
            CLEAR: begin
                if (r_addr == LAST_ADDR) begin
                    w_nxt_state = IDLE;
                    w_nxt_addr  = '0;
                end else begin
                    w_nxt_addr = r_addr + AW'(1);
                end
            end
            IDLE:    w_nxt_state = IDLE;
            default: w_nxt_state = CLEAR;
        endcase
    end

    assign clr_we   = r_clr_we;
    assign clr_addr = r_addr;
    assign ready    = r_ready;

endmodule

// File: rtl/sp_ram_ex.sv
// Single-port byte-writable RAM with selectable read-during-write behaviour and optional output register.
// Define SP_RAM_EX_CLEAR_EN to zero-fill the array after every reset release.
module sp_ram_ex
    import sp_ram_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned WORDS   = 256,
    parameter rdw_mode_e   MODE    = RDW_WRITE_FIRST,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [DW/BYTE_W-1:0]   be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          qout,
    output logic                   qvalid,
    output logic                   ready
);

    localparam int unsigned NB = DW / BYTE_W;
    localparam int unsigned AW = $clog2(WORDS);

    logic [DW-1:0] r_mem [WORDS];

    logic          w_ready;
    logic          w_acc;
    logic          w_in_range;
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_res;
    logic          w_res_vld;

    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_din;
    logic [NB-1:0] w_mem_be;

    logic          r_v1;
    logic [DW-1:0] r_d1;

`ifdef SP_RAM_EX_CLEAR_EN
    sp_ram_clr #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .ready    (w_ready)
    );
`else
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
    assign w_ready    = rst_n;
`endif

    assign ready = w_ready;
    assign w_acc = req & w_ready;

    // Addresses past the last word only exist when the depth is not a power of two.
    if ((32'd1 << AW) == WORDS) begin : g_full_range
        assign w_in_range = 1'b1;
    end else begin : g_part_range
        assign w_in_range = (32'(addr) < WORDS);
    end

    assign w_rd_word = w_in_range ? r_mem[addr] : '0;

    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < int'(NB); b++) begin
            if (be[b]) begin
                w_merged[b*BYTE_W +: BYTE_W] = din[b*BYTE_W +: BYTE_W];
            end
        end
        if (!w_in_range) begin
            w_merged = '0;
        end
    end

    // Result word and whether this access produces a result at all.
    always_comb begin
        w_res     = w_rd_word;
        w_res_vld = w_acc;
        if (we) begin
            case (MODE)
                RDW_WRITE_FIRST: w_res = w_merged;
                RDW_READ_FIRST:  w_res = w_rd_word;
                default:         w_res_vld = 1'b0;
            endcase
        end
    end

    // The clear sequencer owns the array port while it runs; ready is low then.
    always_comb begin
        w_mem_we   = w_acc & we & w_in_range;
        w_mem_addr = addr;
        w_mem_din  = din;
        w_mem_be   = be;
        if (w_clr_we) begin
            w_mem_we   = 1'b1;
            w_mem_addr = w_clr_addr;
            w_mem_din  = '0;
            w_mem_be   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][b*BYTE_W +: BYTE_W] <= w_mem_din[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First result stage; data only moves with a valid so qout holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_res_vld;
            if (w_res_vld) begin
                r_d1 <= w_res;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic          r_v2;
        logic [DW-1:0] r_d2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= r_d1;
                end
            end
        end

        assign qout   = r_d2;
        assign qvalid = r_v2;
    end else begin : g_noreg
        assign qout   = r_d1;
        assign qvalid = r_v1;
    end

endmodule

// File: tb/tb_sp_ram_ex.sv
// Directed bench for sp_ram_ex: five configurations share one stimulus bus.
// Clear-sequence scenarios are built only when SP_RAM_EX_CLEAR_EN is defined.
module tb_sp_ram_ex;
    import sp_ram_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] din;

    logic [31:0] q0, q1, q2, q3, q4;
    logic        v0, v1, v2, v3, v4;
    logic        r0, r1, r2, r3, r4;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sp_ram_ex #(.DW(32), .WORDS(256), .MODE(RDW_WRITE_FIRST), .OUT_REG(0)) d0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .din(din), .qout(q0), .qvalid(v0), .ready(r0));
    sp_ram_ex #(.DW(32), .WORDS(256), .MODE(RDW_READ_FIRST), .OUT_REG(0)) d1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .din(din), .qout(q1), .qvalid(v1), .ready(r1));
    sp_ram_ex #(.DW(32), .WORDS(256), .MODE(RDW_NO_CHANGE), .OUT_REG(1)) d2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr),
        .din(din), .qout(q2), .qvalid(v2), .ready(r2));
    sp_ram_ex #(.DW(32), .WORDS(12), .MODE(RDW_WRITE_FIRST), .OUT_REG(1)) d3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr[3:0]),
        .din(din), .qout(q3), .qvalid(v3), .ready(r3));
    sp_ram_ex #(.DW(32), .WORDS(16), .MODE(RDW_WRITE_FIRST), .OUT_REG(0)) d4 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr[3:0]),
        .din(din), .qout(q4), .qvalid(v4), .ready(r4));

    task automatic cyc(input logic r, input logic w, input logic [3:0] b,
                       input logic [7:0] a, input logic [31:0] d);
        req  = r;
        we   = w;
        be   = b;
        addr = a;
        din  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(r0 && r1 && r2 && r3 && r4) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(r0 && r1 && r2 && r3 && r4)) begin
            errors++;
            $display("FAIL ready_timeout got %b%b%b%b%b exp 11111", r0, r1, r2, r3, r4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++; if (q0 !== 32'h0) begin errors++; $display("FAIL rst_q0 got %h exp 0", q0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL rst_v0 got %b exp 0", v0); end
        checks++; if (q2 !== 32'h0) begin errors++; $display("FAIL rst_q2 got %h exp 0", q2); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL rst_v2 got %b exp 0", v2); end
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", r0); end
        rst_n = 1'b1;
        #1;
`ifdef SP_RAM_EX_CLEAR_EN
        checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL rel_ready got %b exp 0", r4); end
`else
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", r0); end
`endif
        wait_ready();
        idle(1);
    endtask

    task automatic test_write_first();
        cyc(1'b1, 1'b1, 4'hF, 8'd5, 32'hAABBCCDD);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL wf1_v got %b exp 1", v0); end
        checks++; if (q0 !== 32'hAABBCCDD) begin errors++; $display("FAIL wf1_q got %h exp aabbccdd", q0); end
        cyc(1'b1, 1'b1, 4'b0101, 8'd5, 32'h11223344);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL wf2_v got %b exp 1", v0); end
        checks++; if (q0 !== 32'hAA22CC44) begin errors++; $display("FAIL wf2_q got %h exp aa22cc44", q0); end
        checks++; if (q1 !== 32'hAABBCCDD) begin errors++; $display("FAIL rf_old got %h exp aabbccdd", q1); end
        checks++; if (v3 !== 1'b1 || q3 !== 32'hAABBCCDD) begin errors++; $display("FAIL oreg_wf1 got %b/%h exp 1/aabbccdd", v3, q3); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL nc_wr_v got %b exp 0", v2); end
        idle(1);
        checks++; if (v0 !== 1'b0 || q0 !== 32'hAA22CC44) begin errors++; $display("FAIL wf_hold got %b/%h exp 0/aa22cc44", v0, q0); end
        checks++; if (v3 !== 1'b1 || q3 !== 32'hAA22CC44) begin errors++; $display("FAIL oreg_wf2 got %b/%h exp 1/aa22cc44", v3, q3); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL nc_wr_v2 got %b exp 0", v2); end
        idle(1);
    endtask

    task automatic test_byte_enable();
        cyc(1'b1, 1'b1, 4'h0, 8'd5, 32'hFFFFFFFF);
        checks++; if (q0 !== 32'hAA22CC44) begin errors++; $display("FAIL be0_q got %h exp aa22cc44", q0); end
        cyc(1'b1, 1'b1, 4'b1000, 8'd5, 32'h99000000);
        checks++; if (q0 !== 32'h9922CC44) begin errors++; $display("FAIL be8_q got %h exp 9922cc44", q0); end
        cyc(1'b1, 1'b0, 4'h0, 8'd5, 32'h0);
        checks++; if (q1 !== 32'h9922CC44 || v1 !== 1'b1) begin errors++; $display("FAIL be_rd got %b/%h exp 1/9922cc44", v1, q1); end
        idle(2);
    endtask

    task automatic test_read_first();
        cyc(1'b1, 1'b1, 4'hF, 8'd7, 32'h1);
        cyc(1'b1, 1'b1, 4'hF, 8'd7, 32'h2);
        checks++; if (v1 !== 1'b1 || q1 !== 32'h1) begin errors++; $display("FAIL rf_wr got %b/%h exp 1/1", v1, q1); end
        checks++; if (q0 !== 32'h2) begin errors++; $display("FAIL wf_wr got %h exp 2", q0); end
        cyc(1'b1, 1'b0, 4'h0, 8'd7, 32'h0);
        checks++; if (v1 !== 1'b1 || q1 !== 32'h2) begin errors++; $display("FAIL rf_raw got %b/%h exp 1/2", v1, q1); end
        checks++; if (q0 !== 32'h2) begin errors++; $display("FAIL wf_raw got %h exp 2", q0); end
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL nc_wr_none got %b exp 0", v2); end
        idle(1);
        checks++; if (v2 !== 1'b1 || q2 !== 32'h2) begin errors++; $display("FAIL nc_raw got %b/%h exp 1/2", v2, q2); end
        idle(2);
    endtask

    task automatic test_no_change();
        cyc(1'b1, 1'b1, 4'hF, 8'd3, 32'h55);
        idle(2);
        cyc(1'b1, 1'b0, 4'h0, 8'd3, 32'h0);
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL nc_lat1 got %b exp 0", v2); end
        cyc(1'b1, 1'b1, 4'hF, 8'd3, 32'h99);
        checks++; if (v2 !== 1'b1 || q2 !== 32'h55) begin errors++; $display("FAIL nc_rd got %b/%h exp 1/55", v2, q2); end
        idle(1);
        checks++; if (v2 !== 1'b0 || q2 !== 32'h55) begin errors++; $display("FAIL nc_hold1 got %b/%h exp 0/55", v2, q2); end
        idle(1);
        checks++; if (v2 !== 1'b0 || q2 !== 32'h55) begin errors++; $display("FAIL nc_hold2 got %b/%h exp 0/55", v2, q2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic        exp_v;
        vals = '{32'hDEAD0000, 32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF};
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'hF, 8'(i), vals[i]);
        idle(2);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) cyc(1'b1, 1'b0, 4'h0, 8'(k), 32'h0);
            else       idle(1);
            exp_v = (k < 4);
            checks++; if (v0 !== exp_v) begin errors++; $display("FAIL b2b_v0[%0d] got %b exp %b", k, v0, exp_v); end
            if (k < 4) begin
                checks++; if (q0 !== vals[k]) begin errors++; $display("FAIL b2b_q0[%0d] got %h exp %h", k, q0, vals[k]); end
            end
            exp_v = (k >= 1 && k <= 4);
            checks++; if (v3 !== exp_v) begin errors++; $display("FAIL b2b_v3[%0d] got %b exp %b", k, v3, exp_v); end
            if (k >= 1 && k <= 4) begin
                checks++; if (q3 !== vals[k-1]) begin errors++; $display("FAIL b2b_q3[%0d] got %h exp %h", k, q3, vals[k-1]); end
                checks++; if (q2 !== vals[k-1]) begin errors++; $display("FAIL b2b_q2[%0d] got %h exp %h", k, q2, vals[k-1]); end
            end
        end
    endtask

    task automatic test_out_of_range();
        cyc(1'b1, 1'b1, 4'hF, 8'd11, 32'h0B0B0B0B);
        cyc(1'b1, 1'b1, 4'hF, 8'd12, 32'h00000077);
        checks++; if (v3 !== 1'b1 || q3 !== 32'h0B0B0B0B) begin errors++; $display("FAIL oor_w11 got %b/%h exp 1/0b0b0b0b", v3, q3); end
        cyc(1'b1, 1'b0, 4'h0, 8'd11, 32'h0);
        checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL oor_w12_v got %b exp 1", v3); end
        cyc(1'b1, 1'b0, 4'h0, 8'd12, 32'h0);
        checks++; if (v3 !== 1'b1 || q3 !== 32'h0B0B0B0B) begin errors++; $display("FAIL oor_r11 got %b/%h exp 1/0b0b0b0b", v3, q3); end
        checks++; if (v4 !== 1'b1 || q4 !== 32'h77) begin errors++; $display("FAIL inr_r12 got %b/%h exp 1/77", v4, q4); end
        idle(1);
        checks++; if (v3 !== 1'b1 || q3 !== 32'h0) begin errors++; $display("FAIL oor_r12 got %b/%h exp 1/0", v3, q3); end
        idle(1);
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL oor_tail got %b exp 0", v3); end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 4'h0, 8'd11, 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 8'd0, 32'h0);
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (q3 !== 32'h0 || v3 !== 1'b0) begin errors++; $display("FAIL mid_rst_d3 got %b/%h exp 0/0", v3, q3); end
        checks++; if (q0 !== 32'h0 || v0 !== 1'b0) begin errors++; $display("FAIL mid_rst_d0 got %b/%h exp 0/0", v0, q0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL mid_late_v[%0d] got %b exp 0", k, v3); end
        end
        wait_ready();
        idle(1);
    endtask

`ifdef SP_RAM_EX_CLEAR_EN
    task automatic count_clear(input string tag);
        int n = 0;
        while (!r4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL %s got %0d exp 16", tag, n); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'hF, 8'(i), 32'h5A5A0000 | 32'(i));
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("clr_len");
        wait_ready();
        idle(1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 8'(i), 32'h0);
            checks++; if (v4 !== 1'b1 || q4 !== 32'h0) begin errors++; $display("FAIL clr_rd[%0d] got %b/%h exp 1/0", i, v4, q4); end
        end
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'hF, 8'(i), 32'hA5A50000 | 32'(i));
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (r4 !== 1'b0) begin errors++; $display("FAIL clr_rst_ready got %b exp 0", r4); end
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("clr_restart_len");
        wait_ready();
        idle(1);
        cyc(1'b1, 1'b0, 4'h0, 8'd0, 32'h0);
        checks++; if (q4 !== 32'h0) begin errors++; $display("FAIL clr_rs0 got %h exp 0", q4); end
        cyc(1'b1, 1'b0, 4'h0, 8'd9, 32'h0);
        checks++; if (q4 !== 32'h0) begin errors++; $display("FAIL clr_rs9 got %h exp 0", q4); end
        cyc(1'b1, 1'b0, 4'h0, 8'd15, 32'h0);
        checks++; if (q4 !== 32'h0) begin errors++; $display("FAIL clr_rs15 got %h exp 0", q4); end
        idle(1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = 8'h00;
        din   = 32'h0;
        test_reset();
        test_write_first();
        test_byte_enable();
        test_read_first();
        test_no_change();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef SP_RAM_EX_CLEAR_EN
        test_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sp_ram_ex.md
SP_RAM_EX -- requirements
Module: sp_ram_ex

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; must be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter WORDS, default 256, depth in words; must be at least 2.
REQ-003 SHALL have parameter MODE, default RDW_WRITE_FIRST, read-during-write behaviour: RDW_WRITE_FIRST, RDW_READ_FIRST or RDW_NO_CHANGE.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds one output pipeline register.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port req, input, 1 bit, access request for the current cycle.
REQ-008 SHALL have port we, input, 1 bit, write when high, read when low; qualified by req.
REQ-009 SHALL have port be, input, DW/8 bits, byte-lane write enables; bit i covers din[8i+7:8i].
REQ-010 SHALL have port addr, input, $clog2(WORDS) bits, word address.
REQ-011 SHALL have port din, input, DW bits, write data.
REQ-012 SHALL have port qout, output, DW bits, read data.
REQ-013 SHALL have port qvalid, output, 1 bit, high for one cycle when qout carries a new result.
REQ-014 SHALL have port ready, output, 1 bit, high when requests are accepted.

Function
REQ-015 SHALL accept an access when req and ready are both high; req is ignored while ready is low.
REQ-016 SHALL update only the lanes of ram[addr] whose be bit is set on an accepted write; a write with be=0 leaves memory unchanged.
REQ-017 SHALL return ram[addr] on qout for an accepted read, with qvalid high LAT=1+OUT_REG cycles after acceptance.
REQ-018 SHALL, on an accepted write in RDW_WRITE_FIRST, return the post-write merged word with qvalid after LAT cycles.
REQ-019 SHALL, on an accepted write in RDW_READ_FIRST, return the pre-write word with qvalid after LAT cycles.
REQ-020 SHALL, on an accepted write in RDW_NO_CHANGE, hold qout and produce no qvalid for that access.
REQ-021 SHALL hold qout between results; qout changes only in a cycle where qvalid is high.
REQ-022 SHALL accept back-to-back accesses every cycle; results leave in acceptance order at full throughput.
REQ-023 SHALL produce qout equal to the data written, in every mode, for a read issued in the cycle after a write to the same address.
REQ-024 SHALL treat addr values of WORDS or above, when WORDS is not a power of two, as no-ops: writes are dropped and reads return zero with normal qvalid timing.

Reset
REQ-025 SHALL, while rst_n is low, force qout=0, qvalid=0 and all pipeline valid bits to 0 asynchronously.
REQ-026 SHALL discard any in-flight result when reset asserts mid-pipeline; no qvalid follows for it.
REQ-027 SHALL leave memory contents untouched by reset unless SP_RAM_EX_CLEAR_EN is defined.

Configuration
REQ-028 SHALL, with macro SP_RAM_EX_CLEAR_EN defined, include a clear sequencer with states CLEAR and IDLE, entering CLEAR when rst_n rises.
REQ-029 SHALL, in CLEAR, write zero to address 0..WORDS-1 at one word per cycle, hold ready low, then go to IDLE with ready high in the cycle after address WORDS-1 is written.
REQ-030 SHALL restart the clear sequence from address 0 if reset asserts during CLEAR.
REQ-031 SHALL, without SP_RAM_EX_CLEAR_EN, tie ready to 1 whenever rst_n is high, contain no sequencer, and leave initial memory contents undefined.

Structure
REQ-032 SHALL place enum rdw_mode_e (RDW_WRITE_FIRST, RDW_READ_FIRST, RDW_NO_CHANGE) and constant BYTE_W=8 in package sp_ram_pkg.
REQ-033 SHALL implement the clear sequencer as sub-module sp_ram_clr with outputs clr_we, clr_addr and ready.

Verification
REQ-034 SHALL cover this case (DW=32, MODE=RDW_WRITE_FIRST, OUT_REG=0): write 0xAABBCCDD to addr 5 with be=1111, then write 0x11223344 to addr 5 with be=0101 -> second qout=0xAA22CC44, qvalid 1 cycle after each write.
REQ-035 SHALL cover this case (MODE=RDW_READ_FIRST): addr 7 holds 0x1, write 0x2 to addr 7 -> qout=0x1; read addr 7 next cycle -> qout=0x2.
REQ-036 SHALL cover this case (MODE=RDW_NO_CHANGE, OUT_REG=1): read addr 3 returning 0x55, then write addr 3 -> qout stays 0x55, single qvalid 2 cycles after the read.
REQ-037 SHALL cover this case (OUT_REG=1): 4 consecutive reads of addr 0..3 -> 4 consecutive qvalid pulses starting 2 cycles after the first read, data in order.
REQ-038 SHALL cover this case (SP_RAM_EX_CLEAR_EN, WORDS=16): release rst_n -> ready low for 16 cycles, reads of addresses 0..15 then return 0; assert rst_n at clear address 9 -> clear restarts at 0.
REQ-039 SHALL cover this case: assert rst_n low one cycle after a read is accepted with OUT_REG=1 -> qout=0, qvalid=0, and no late qvalid after release.
